hpu_id_dsq: RTL and testbench

Rename-to-dispatch slot queue. Captures each renamed group leaving the id1 rename stage (up to PARAL instructions per cycle). It compacts away inactive slots and presents the oldest PARAL instructions to dispatch, which may take 0..PARAL of them per cycle. It drives the stall that back-pressures decode/rename, and it empties on pipeline flush or checkpoint recovery.

---
 rtl/hpu_id_dsq.sv | 89 ++++++++
 tb/tb_hpu_id_dsq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hpu_id_dsq.sv
// Rename-to-dispatch slot queue: compacts active slots of each renamed group into a ring
// and presents the oldest PARAL entries as the dispatch window.
module hpu_id_dsq #(
  parameter int PARAL  = 2,
  parameter int DEPTH  = 8,
  parameter int SLOT_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_en_i,
  input  logic                         ckpt_rcov_en_i,
  input  logic                         grp_vld_i,
  input  logic [PARAL-1:0]             slot_act_i,
  input  logic [PARAL*SLOT_W-1:0]      slot_data_i,
  output logic [PARAL-1:0]             dsp_vld_o,
  output logic [PARAL*SLOT_W-1:0]      dsp_data_o,
  input  logic [$clog2(PARAL+1)-1:0]   dsp_take_i,
  output logic                         stall_o,
  output logic [$clog2(DEPTH):0]       cnt_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [SLOT_W-1:0] r_mem [DEPTH];
  logic [IW:0]       r_head;
  logic [IW:0]       r_tail;

  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_free;
  logic              w_stall;
  logic              w_clear;
  logic              w_enq;
  logic [CW-1:0]     w_n_in;
  logic [CW-1:0]     w_take;
  logic [CW-1:0]     w_n_out;
  logic [IW-1:0]     w_off [PARAL];
  logic [CW-1:0]     w_acc;

  // Pointers carry a wrap flag in the MSB, so the difference is the true occupancy even when full.
  assign w_cnt   = r_tail - r_head;
  assign w_free  = CW'(DEPTH) - w_cnt;
  assign w_stall = (w_free < CW'(PARAL));
  assign w_clear = rst_i | flush_en_i | ckpt_rcov_en_i;
  assign w_enq   = grp_vld_i & ~w_stall & ~w_clear;
  assign w_take  = CW'(dsp_take_i);
  assign w_n_out = (w_take > w_cnt) ? w_cnt : w_take;

  assign stall_o = w_stall;
  assign cnt_o   = w_cnt;

  // Each active slot lands at tail plus the number of active slots below it.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < PARAL; i++) begin
      w_off[i] = w_acc[IW-1:0];
      if (slot_act_i[i]) w_acc = w_acc + CW'(1);
    end
    w_n_in = w_acc;
  end

  always_comb begin
    dsp_vld_o  = '0;
    dsp_data_o = '0;
    for (int k = 0; k < PARAL; k++) begin
      dsp_vld_o[k]                  = (CW'(k) < w_cnt);
      dsp_data_o[k*SLOT_W +: SLOT_W] = r_mem[r_head[IW-1:0] + IW'(k)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + w_n_out;
      if (w_enq) r_tail <= r_tail + w_n_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      for (int i = 0; i < PARAL; i++) begin
        if (slot_act_i[i]) r_mem[r_tail[IW-1:0] + w_off[i]] <= slot_data_i[i*SLOT_W +: SLOT_W];
      end
    end
  end

endmodule

// File: tb/tb_hpu_id_dsq.sv
// Directed bench for hpu_id_dsq (PARAL=2, DEPTH=8) with hand-computed expectations.
module tb_hpu_id_dsq;

  localparam int PARAL  = 2;
  localparam int DEPTH  = 8;
  localparam int SLOT_W = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 flush_en_i;
  logic                 ckpt_rcov_en_i;
  logic                 grp_vld_i;
  logic [PARAL-1:0]     slot_act_i;
  logic [PARAL*SLOT_W-1:0] slot_data_i;
  logic [PARAL-1:0]     dsp_vld_o;
  logic [PARAL*SLOT_W-1:0] dsp_data_o;
  logic [1:0]           dsp_take_i;
  logic                 stall_o;
  logic [3:0]           cnt_o;

  int n_vec = 0;
  int n_err = 0;

  hpu_id_dsq #(.PARAL(PARAL), .DEPTH(DEPTH), .SLOT_W(SLOT_W)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_en_i     (flush_en_i),
    .ckpt_rcov_en_i (ckpt_rcov_en_i),
    .grp_vld_i      (grp_vld_i),
    .slot_act_i     (slot_act_i),
    .slot_data_i    (slot_data_i),
    .dsp_vld_o      (dsp_vld_o),
    .dsp_data_o     (dsp_data_o),
    .dsp_take_i     (dsp_take_i),
    .stall_o        (stall_o),
    .cnt_o          (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] act, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] take);
    grp_vld_i   = vld;
    slot_act_i  = act;
    slot_data_i = {d1, d0};
    dsp_take_i  = take;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    flush_en_i     = 1'b0;
    ckpt_rcov_en_i = 1'b0;
    rst_i          = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush_en_i = 1'b1;
    tick();
    flush_en_i = 1'b0;
  endtask

  function automatic logic [31:0] slot(input int k);
    return dsp_data_o[k*SLOT_W +: SLOT_W];
  endfunction

  function automatic logic [31:0] gdat(input int j, input int s);
    return 32'hC0DE_0000 + 32'(j * 2 + s);
  endfunction

  initial begin
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_vld",   64'(dsp_vld_o), 64'h0);
    chk("rst_cnt",   64'(cnt_o),     64'h0);
    chk("rst_stall", 64'(stall_o),   64'h0);

    // full group
    drive(1'b1, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'd0);
    tick();
    idle();
    chk("g11_vld",   64'(dsp_vld_o), 64'h3);
    chk("g11_s0",    64'(slot(0)),   64'hAAAA_0001);
    chk("g11_s1",    64'(slot(1)),   64'hBBBB_0002);
    chk("g11_cnt",   64'(cnt_o),     64'h2);
    chk("g11_stall", 64'(stall_o),   64'h0);
    do_flush();
    chk("flush_cnt", 64'(cnt_o),     64'h0);
    chk("flush_vld", 64'(dsp_vld_o), 64'h0);

    // compaction: only slot1 active
    drive(1'b1, 2'b10, 32'h1111_000A, 32'h2222_000B, 2'd0);
    tick();
    chk("g10_vld", 64'(dsp_vld_o), 64'h1);
    chk("g10_s0",  64'(slot(0)),   64'h2222_000B);
    chk("g10_cnt", 64'(cnt_o),     64'h1);
    drive(1'b1, 2'b00, 32'hDEAD_0000, 32'hDEAD_0001, 2'd0);
    tick();
    idle();
    chk("g00_cnt", 64'(cnt_o),     64'h1);
    chk("g00_s0",  64'(slot(0)),   64'h2222_000B);
    do_flush();

    // fill to full, then drain one at a time
    for (int g = 0; g < 4; g++) begin
      drive(1'b1, 2'b11, 32'hD000_0000 + 32'(2*g), 32'hD000_0001 + 32'(2*g), 2'd0);
      tick();
    end
    chk("full_cnt",   64'(cnt_o),   64'h8);
    chk("full_stall", 64'(stall_o), 64'h1);
    drive(1'b1, 2'b11, 32'hEEEE_0000, 32'hEEEE_0001, 2'd0);
    tick();
    chk("ign_cnt", 64'(cnt_o),   64'h8);
    chk("ign_s0",  64'(slot(0)), 64'hD000_0000);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd1);
    tick();
    chk("t1_cnt",   64'(cnt_o),   64'h7);
    chk("t1_stall", 64'(stall_o), 64'h1);
    chk("t1_s0",    64'(slot(0)), 64'hD000_0001);
    tick();
    idle();
    chk("t2_cnt",   64'(cnt_o),   64'h6);
    chk("t2_stall", 64'(stall_o), 64'h0);
    chk("t2_s0",    64'(slot(0)), 64'hD000_0002);
    chk("t2_s1",    64'(slot(1)), 64'hD000_0003);
    do_flush();

    // streaming with wrap
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 2'b11, gdat(j, 0), gdat(j, 1), 2'd2);
      tick();
      chk("str_cnt", 64'(cnt_o),   64'h2);
      chk("str_s0",  64'(slot(0)), 64'(gdat(j, 0)));
      chk("str_s1",  64'(slot(1)), 64'(gdat(j, 1)));
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2);
    tick();
    idle();
    chk("str_drain", 64'(cnt_o), 64'h0);

    // recovery discards same-cycle enqueue and take
    drive(1'b1, 2'b11, 32'h5000_0000, 32'h5000_0001, 2'd0);
    tick();
    drive(1'b1, 2'b11, 32'h5000_0002, 32'h5000_0003, 2'd0);
    tick();
    drive(1'b1, 2'b01, 32'h5000_0004, 32'h5000_0005, 2'd0);
    tick();
    chk("c5_cnt", 64'(cnt_o), 64'h5);
    drive(1'b1, 2'b11, 32'h2222_2222, 32'h3333_3333, 2'd2);
    ckpt_rcov_en_i = 1'b1;
    tick();
    idle();
    chk("rcov_cnt",   64'(cnt_o),     64'h0);
    chk("rcov_vld",   64'(dsp_vld_o), 64'h0);
    chk("rcov_stall", 64'(stall_o),   64'h0);
    drive(1'b1, 2'b11, 32'h7777_0000, 32'h7777_0001, 2'd0);
    tick();
    idle();
    chk("post_rcov_s0",  64'(slot(0)), 64'h7777_0000);
    chk("post_rcov_s1",  64'(slot(1)), 64'h7777_0001);
    chk("post_rcov_cnt", 64'(cnt_o),   64'h2);
    do_flush();

    // over-take clamps at empty
    drive(1'b1, 2'b01, 32'h9999_0001, 32'h9999_0002, 2'd0);
    tick();
    chk("ot_cnt1", 64'(cnt_o), 64'h1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2);
    tick();
    chk("ot_cnt0", 64'(cnt_o),     64'h0);
    chk("ot_vld",  64'(dsp_vld_o), 64'h0);
    drive(1'b1, 2'b11, 32'hABCD_0000, 32'hABCD_0001, 2'd0);
    tick();
    idle();
    chk("ot_next_cnt", 64'(cnt_o),   64'h2);
    chk("ot_next_s0",  64'(slot(0)), 64'hABCD_0000);

    // reset mid-operation
    drive(1'b1, 2'b11, 32'h4444_0000, 32'h4444_0001, 2'd0);
    tick();
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mrst_cnt", 64'(cnt_o),     64'h0);
    chk("mrst_vld", 64'(dsp_vld_o), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
